// File: rtl/digit_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : digit_scan_pkg
//  Purpose  : Shared types and constants for the multiplexed 7-segment
//             display controller (segment codes, BCD digit type, enable
//             helper).
//  Revision : 1.0  initial release
// ============================================================================
package digit_scan_pkg;

  // One BCD digit; codes 10..15 are treated as blank
  typedef logic [3:0] bcd_t;

  // Segment patterns, active-low, written in a..g order (bit 0 = a)
  localparam logic [0:6] SEG_D0    = 7'b0000001;
  localparam logic [0:6] SEG_D1    = 7'b1001111;
  localparam logic [0:6] SEG_D2    = 7'b0010010;
  localparam logic [0:6] SEG_D3    = 7'b0000110;
  localparam logic [0:6] SEG_D4    = 7'b1001100;
  localparam logic [0:6] SEG_D5    = 7'b0100100;
  localparam logic [0:6] SEG_D6    = 7'b0100000;
  localparam logic [0:6] SEG_D7    = 7'b0001111;
  localparam logic [0:6] SEG_D8    = 7'b0000000;
  localparam logic [0:6] SEG_D9    = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  // Widest supported digit count
  localparam int unsigned MAX_DIG = 8;

  // All digit enables released (active-low, so all ones); callers slice
  function automatic logic [MAX_DIG-1:0] DIG_OFF();
    return '1;
  endfunction

endpackage : digit_scan_pkg
`default_nettype wire

// File: rtl/bcd_seg_lut.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seg_lut
//  Purpose  : Combinational BCD to active-low 7-segment decoder. Codes
//             10..15 decode to an all-dark pattern.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_seg_lut
  import digit_scan_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [0:6] o_seg
);

  // Straight table lookup, non-decimal codes go dark
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_D0;
      4'd1:    o_seg = SEG_D1;
      4'd2:    o_seg = SEG_D2;
      4'd3:    o_seg = SEG_D3;
      4'd4:    o_seg = SEG_D4;
      4'd5:    o_seg = SEG_D5;
      4'd6:    o_seg = SEG_D6;
      4'd7:    o_seg = SEG_D7;
      4'd8:    o_seg = SEG_D8;
      4'd9:    o_seg = SEG_D9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule : bcd_seg_lut
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : digit_scan_ctrl
//  Purpose  : Time-multiplexed 7-segment controller. Holds a frame of BCD
//             digits, scans them round-robin every PRESCALE cycles through
//             one shared decoder, and swaps in newly loaded frames only at
//             frame boundaries so the display never tears.
//  Options  : `define LEADING_ZERO_BLANK_EN to blank leading zeros
//             (digit 0 is always shown).
//  Revision : 1.0  initial release
// ============================================================================
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int PRESCALE = 50000
)(
  input  logic                       CLOCK_50,
  input  logic                       RESET_N,
  input  logic                       load_valid,
  input  logic [4*N_DIG-1:0]         load_data,
  output logic                       load_ready,
  output logic [0:6]                 seg,
  output logic [N_DIG-1:0]           dig_en,
  output logic [$clog2(N_DIG)-1:0]   scan_idx
);

  localparam int                     c_idx_w    = $clog2(N_DIG);
  localparam int                     c_cnt_w    = $clog2(PRESCALE);
  localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(PRESCALE - 1);
  localparam logic [c_idx_w-1:0]     c_idx_last = c_idx_w'(N_DIG - 1);
  localparam logic [MAX_DIG-1:0]     c_all_off  = DIG_OFF();
  localparam logic [N_DIG-1:0]       c_dig_off  = c_all_off[N_DIG-1:0];
  localparam logic [N_DIG-1:0]       c_dig_one  = {{(N_DIG-1){1'b0}}, 1'b1};

  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_idx_w-1:0]     r_idx;
  bcd_t [N_DIG-1:0]       r_act;
  bcd_t [N_DIG-1:0]       r_pend;
  logic                   r_pend_v;
  logic [0:6]             r_seg;
  logic [N_DIG-1:0]       r_dig_en;

  logic                   w_tick;
  logic                   w_wrap;
  logic                   w_xfer;
  logic [N_DIG-1:0]       w_blank_mask;
  bcd_t                   w_lut_in;
  logic [0:6]             w_lut_out;

  assign w_tick     = (r_cnt == c_cnt_last);
  assign w_wrap     = w_tick && (r_idx == c_idx_last);
  assign load_ready = !r_pend_v;
  assign w_xfer     = load_valid && load_ready;

  assign seg        = r_seg;
  assign dig_en     = r_dig_en;
  assign scan_idx   = r_idx;

  // Slot prescaler: free-running, its wrap marks the end of a digit slot
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Scan position: advance one digit per slot, round-robin
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
    end
  end

  // Frame buffering: pending slot fills on handshake, drains into the
  // active frame only at a frame wrap. A load can only land while the
  // pending slot is empty, so fill and drain never collide; a load on the
  // wrap cycle itself waits for the next wrap.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_act    <= {N_DIG{4'hF}};
      r_pend   <= {N_DIG{4'hF}};
      r_pend_v <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_pend   <= load_data;
        r_pend_v <= 1'b1;
      end else if (w_wrap && r_pend_v) begin
        r_act    <= r_pend;
        r_pend_v <= 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero suppression: walk down from the top digit while all
  // digits seen so far are zero or blank codes; digit 0 is never blanked
  always_comb begin
    logic w_quiet;
    w_blank_mask = '0;
    w_quiet      = 1'b1;
    for (int i = N_DIG - 1; i > 0; i--) begin
      if (w_quiet && (r_act[i] == 4'd0)) begin
        w_blank_mask[i] = 1'b1;
      end
      w_quiet = w_quiet && ((r_act[i] == 4'd0) || (r_act[i] > 4'd9));
    end
  end
`else
  assign w_blank_mask = '0;
`endif

  // Shared decoder input: current digit, or a blank code when suppressed
  always_comb begin
    w_lut_in = w_blank_mask[r_idx] ? 4'hF : r_act[r_idx];
  end

  bcd_seg_lut u_lut (
    .i_bcd (w_lut_in),
    .o_seg (w_lut_out)
  );

  // Output register: first cycle of each slot is dark to avoid ghosting
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_seg    <= SEG_BLANK;
      r_dig_en <= c_dig_off;
    end else if (r_cnt == '0) begin
      r_seg    <= SEG_BLANK;
      r_dig_en <= c_dig_off;
    end else begin
      r_seg    <= w_lut_out;
      r_dig_en <= c_dig_off & ~(c_dig_one << r_idx);
    end
  end

endmodule : digit_scan_ctrl
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_scan_ctrl
//  Purpose  : Self-checking bench for digit_scan_ctrl (N_DIG=4, PRESCALE=4).
//             Accepted frames are queued with the frame in which they must
//             appear; a negedge monitor pops them and checks every output
//             cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_digit_scan_ctrl;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int FR = N * P;

  logic        CLOCK_50   = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data  = 16'h0;
  logic        load_ready;
  logic [0:6]  seg;
  logic [3:0]  dig_en;
  logic [1:0]  scan_idx;

  digit_scan_ctrl #(.N_DIG(N), .PRESCALE(P)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .seg        (seg),
    .dig_en     (dig_en),
    .scan_idx   (scan_idx)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          t;      // clock edge number of the transfer
    int          apply;  // frame index from which it is displayed
    logic [15:0] data;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] cur   = 16'hFFFF;
  int          n     = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // Edges since reset release
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) n <= 0;
    else          n <= n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @n=%0d: got %h, expected %h", tag, n, got, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_digit(input logic [15:0] f, input int d);
    logic [3:0] v;
    v = f[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && v == 4'd0) begin
      bit q;
      q = 1'b1;
      for (int j = d + 1; j < N; j++)
        if (!(f[4*j +: 4] == 4'd0 || f[4*j +: 4] > 4'd9)) q = 1'b0;
      if (q) return 7'b1111111;
    end
`endif
    return dec(v);
  endfunction

  // Monitor: every cycle out of reset, compare against the queued frames
  always @(negedge CLOCK_50) begin : mon
    int         pos;
    int         d;
    int         k;
    logic [6:0] es;
    logic [3:0] ee;
    logic       er;
    if (RESET_N) begin
      er = 1'b1;
      foreach (sb[i]) if (sb[i].t <= n && n < FR * sb[i].apply) er = 1'b0;
      check("load_ready", {31'b0, load_ready}, {31'b0, er});
      check("scan_idx", {30'b0, scan_idx}, (n / P) % N);
      if (n == 0) begin
        es = 7'b1111111;
        ee = 4'b1111;
      end else begin
        k   = (n - 1) / FR;
        pos = (n - 1) % FR;
        d   = pos / P;
        while (sb.size() > 0 && sb[0].apply <= k) begin
          cur = sb[0].data;
          sb.delete(0);
        end
        if (pos % P == 0) begin
          es = 7'b1111111;
          ee = 4'b1111;
        end else begin
          es = exp_digit(cur, d);
          ee = 4'b1111 & ~(4'b0001 << d);
        end
      end
      check("seg", {25'b0, seg}, {25'b0, es});
      check("dig_en", {28'b0, dig_en}, {28'b0, ee});
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge CLOCK_50);
      load_data = 16'($urandom);
    end
  endtask

  // Offer a frame and hold it until accepted; the transfer edge is n+1
  task automatic offer(input logic [15:0] v);
    bit   done;
    ent_t e;
    done       = 1'b0;
    load_valid = 1'b1;
    load_data  = v;
    for (int i = 0; i < 8 * FR && !done; i++) begin
      if (load_ready === 1'b1) begin
        e.t     = n + 1;
        e.apply = (n + 1) / FR + 1;
        e.data  = v;
        sb.push_back(e);
        done = 1'b1;
      end
      @(negedge CLOCK_50);
    end
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    if (!done) check("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_seg"},    {25'b0, seg},        {25'b0, 7'b1111111});
    check({tag, "_dig_en"}, {28'b0, dig_en},     32'hF);
    check({tag, "_ready"},  {31'b0, load_ready}, 32'd1);
    check({tag, "_idx"},    {30'b0, scan_idx},   32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    #1 reset_values("rst");
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    idle(5);

    // Basic scan
    offer(16'h1234);
    idle(2 * FR + 4);

    // Backpressure: second frame waits for the first to be applied
    offer(16'h1111);
    offer(16'h2222);
    idle(3 * FR);

    // Transfer on the frame-wrap edge itself
    for (int i = 0; i < FR && (n % FR) != FR - 1; i++) @(negedge CLOCK_50);
    offer(16'h5678);
    idle(3 * FR);

    // Non-decimal codes and zero patterns
    offer(16'hA9F0);
    idle(2 * FR);
    offer(16'h0050);
    idle(2 * FR);
    offer(16'h0000);
    idle(2 * FR);

    // Reset while a frame is pending: it must be discarded
    for (int i = 0; i < FR && (n % FR) != 0; i++) @(negedge CLOCK_50);
    offer(16'h9999);
    repeat (3) @(negedge CLOCK_50);
    #3 RESET_N = 1'b0;
    sb.delete();
    cur = 16'hFFFF;
    #1 reset_values("midrst");
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    idle(2 * FR);

    offer(16'h8765);
    idle(3 * FR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_digit_scan_ctrl
`default_nettype wire
